// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the data SRAM responder: port widths, FSM states
// and the address window decode used by the EX/MEM data bus.
package dsram_responder_pkg;

  localparam int unsigned DSRAM_ADDR_W = 32;
  localparam int unsigned DSRAM_DATA_W = 32;
  localparam int unsigned DSRAM_WEN_W  = DSRAM_DATA_W / 8;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } dsram_state_e;

  // off is the byte offset from the window base; anything above the word-index
  // bits means the request falls outside the mapped array.
  function automatic logic dsram_in_window(input logic [DSRAM_ADDR_W-1:0] off,
                                           input int unsigned addr_w);
    return (off >> (addr_w + 2)) == '0;
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// Data SRAM port between the execute/memory stages and the responder.
interface dsram_responder_if;
  import dsram_responder_pkg::*;

  logic                    data_sram_en;
  logic [DSRAM_WEN_W-1:0]  data_sram_wen;
  logic [DSRAM_ADDR_W-1:0] data_sram_addr;
  logic [DSRAM_DATA_W-1:0] data_sram_wdata;
  logic [DSRAM_DATA_W-1:0] data_sram_rdata;
  logic                    stallreq;
  logic                    addr_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq, addr_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq, addr_err
  );
endinterface

// File: rtl/dsram_responder_bytebank.sv
// One byte lane of the data SRAM: DEPTH x 8 single-port array, registered read.
module dsram_bytebank #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end
endmodule

// File: rtl/dsram_responder.sv
// Data SRAM responder: byte-writable word RAM with one-cycle reads, a post-reset
// zero-fill sequencer that stalls the pipeline, and an out-of-window flag.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 12,
  parameter logic [31:0]       BASE_ADDR      = 32'h0000_0000,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  dsram_responder_if.slave    bus
);

  dsram_state_e                state_q, state_d;
  logic [ADDR_W-1:0]           clr_ptr_q, clr_ptr_d;
  logic                        clearing;
  logic                        ready;

  logic [DSRAM_ADDR_W-1:0]     off;
  logic [ADDR_W-1:0]           idx;
  logic                        in_range;
  logic                        rd_req;
  logic                        oor_req;

  logic [ADDR_W-1:0]           bank_addr;
  logic [DSRAM_DATA_W-1:0]     bank_din;
  logic [DSRAM_DATA_W-1:0]     bank_q;
  logic [DSRAM_WEN_W-1:0]      lane_we;

  logic                        rd_pend_q;
  logic [DSRAM_DATA_W-1:0]     rdata_q;
  logic                        addr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == S_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == '1) state_d = S_READY;
    end
  end

  assign clearing = (state_q == S_CLEAR);
  assign ready    = (state_q == S_READY);

  assign off      = bus.data_sram_addr - BASE_ADDR;
  assign idx      = off[ADDR_W+1:2];
  assign in_range = dsram_in_window(off, ADDR_W);
  assign rd_req   = ready & bus.data_sram_en & in_range & (bus.data_sram_wen == '0);
  assign oor_req  = ready & bus.data_sram_en & ~in_range;

  assign bank_addr = clearing ? clr_ptr_q : idx;
  assign bank_din  = clearing ? '0 : bus.data_sram_wdata;

  for (genvar i = 0; i < DSRAM_WEN_W; i++) begin : g_lane
    assign lane_we[i] = clearing | (bus.data_sram_en & bus.data_sram_wen[i] & in_range);

    dsram_bytebank #(.ADDR_W(ADDR_W)) u_bank (
      .clk  (clk),
      .we   (lane_we[i]),
      .re   (rd_req),
      .addr (bank_addr),
      .din  (bank_din[8*i +: 8]),
      .dout (bank_q[8*i +: 8])
    );
  end

  // The banks already register the read, so rdata shows the bank output in the
  // cycle after a load and otherwise a captured copy that holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_req;
      addr_err_q <= oor_req;
      if (oor_req)        rdata_q <= '0;
      else if (rd_pend_q) rdata_q <= bank_q;
    end
  end

  assign bus.data_sram_rdata = rd_pend_q ? bank_q : rdata_q;
  assign bus.stallreq        = clearing;
  assign bus.addr_err        = addr_err_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder against a word-array reference model.
module tb_dsram_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsram_responder_if bus ();

  dsram_responder #(
    .ADDR_W         (ADDR_W),
    .BASE_ADDR      (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_rdata;
  logic        exp_err;

  function automatic bit mdl_in_range(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 4 * DEPTH;
  endfunction

  function automatic int unsigned mdl_idx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o / 4) % DEPTH;
  endfunction

  // One request in the ready state; the reference model is updated alongside.
  task automatic do_req(input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    bus.data_sram_en  = 1'b0;
    bus.data_sram_wen = 4'b0000;
    exp_err = 1'b0;
    if (en) begin
      if (!mdl_in_range(addr)) begin
        exp_rdata = 32'h0;
        exp_err   = 1'b1;
      end else if (wen == 4'b0000) begin
        exp_rdata = model[mdl_idx(addr)];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wen[b]) model[mdl_idx(addr)][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.data_sram_en = 1'b0;
    bus.data_sram_wen = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int unsigned cnt;
    cnt = 0;
    while (bus.stallreq === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    total++;
    if (cnt != DEPTH) begin
      bad++;
      $display("FAIL %s: stallreq cycles got %0d want %0d", name, cnt, DEPTH);
    end
    for (int w = 0; w < DEPTH; w++) model[w] = 32'h0;
  endtask

  task automatic check_all_words(input string name);
    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b1, 4'b0000, BASE + 32'(w) * 4, 32'h0);
      total++;
      if (bus.data_sram_rdata !== exp_rdata || bus.addr_err !== 1'b0) begin
        bad++;
        $display("FAIL %s word %0d: got %h err %b want %h err 0",
                 name, w, bus.data_sram_rdata, bus.addr_err, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (bus.stallreq !== 1'b1 || bus.data_sram_rdata !== 32'h0 || bus.addr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: got stall %b rdata %h err %b want 1 00000000 0",
               bus.stallreq, bus.data_sram_rdata, bus.addr_err);
    end
  endtask

  task automatic test_clear();
    count_clear("clear_len");
    check_all_words("clear_zero");
  endtask

  task automatic test_full_word();
    do_req(1'b1, 4'b1111, BASE + 32'h10, 32'hDEAD_BEEF);
    do_req(1'b1, 4'b0000, BASE + 32'h10, 32'h0);
    total++;
    if (bus.data_sram_rdata !== 32'hDEAD_BEEF || bus.addr_err !== 1'b0) begin
      bad++;
      $display("FAIL full_word: got %h err %b want deadbeef err 0",
               bus.data_sram_rdata, bus.addr_err);
    end
  endtask

  task automatic test_lanes();
    do_req(1'b1, 4'b1111, BASE + 32'h20, 32'h1122_3344);
    do_req(1'b1, 4'b0100, BASE + 32'h20, 32'hAAAA_AAAA);
    do_req(1'b1, 4'b0011, BASE + 32'h20, 32'h5566_5566);
    do_req(1'b0, 4'b1111, BASE + 32'h20, 32'hFFFF_FFFF);
    do_req(1'b1, 4'b0000, BASE + 32'h22, 32'h0);
    total++;
    if (bus.data_sram_rdata !== 32'h11AA_5566) begin
      bad++;
      $display("FAIL lanes: got %h want 11aa5566", bus.data_sram_rdata);
    end
  endtask

  task automatic test_out_of_range();
    do_req(1'b1, 4'b0000, BASE + 32'h10, 32'h0);
    do_req(1'b1, 4'b0000, 32'h0FFF_FFFC, 32'h0);
    total++;
    if (bus.data_sram_rdata !== 32'h0 || bus.addr_err !== 1'b1) begin
      bad++;
      $display("FAIL oor_low: got %h err %b want 00000000 err 1",
               bus.data_sram_rdata, bus.addr_err);
    end
    do_req(1'b0, 4'b0000, BASE, 32'h0);
    total++;
    if (bus.addr_err !== 1'b0 || bus.data_sram_rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_pulse: got err %b rdata %h want err 0 rdata 0",
               bus.addr_err, bus.data_sram_rdata);
    end
    do_req(1'b1, 4'b1111, BASE + 4 * DEPTH, 32'hCAFE_F00D);
    total++;
    if (bus.addr_err !== 1'b1) begin
      bad++;
      $display("FAIL oor_store_err: got %b want 1", bus.addr_err);
    end
    check_all_words("oor_untouched");
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa, la, d;
    logic [3:0]  wen;
    for (int i = 0; i < 64; i++) begin
      sa  = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
      d   = $urandom;
      wen = 4'($urandom_range(1, 15));
      do_req(1'b1, wen, sa, d);
      la  = ($urandom_range(0, 1) == 1) ? sa :
            BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
      do_req(1'b1, 4'b0000, la, 32'h0);
      total++;
      if (bus.data_sram_rdata !== exp_rdata || bus.addr_err !== 1'b0) begin
        bad++;
        $display("FAIL b2b[%0d] addr %h: got %h err %b want %h err 0",
                 i, la, bus.data_sram_rdata, bus.addr_err, exp_rdata);
      end
      if ($urandom_range(0, 3) == 0) begin
        do_req(1'b0, 4'($urandom), sa, $urandom);
        total++;
        if (bus.data_sram_rdata !== exp_rdata) begin
          bad++;
          $display("FAIL b2b_hold[%0d]: got %h want %h", i, bus.data_sram_rdata, exp_rdata);
        end
      end
    end
    check_all_words("b2b_final");
  endtask

  task automatic test_reset_mid_clear();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = 4'b1111;
      bus.data_sram_addr  = BASE + 32'(c) * 4 + 32'h20;
      bus.data_sram_wdata = 32'h5A5A_0000 | 32'(c);
      @(posedge clk);
      #1;
      bus.data_sram_en = 1'b0;
      total++;
      if (bus.data_sram_rdata !== 32'h0 || bus.addr_err !== 1'b0) begin
        bad++;
        $display("FAIL clear_blocked[%0d]: got %h err %b want 0 err 0",
                 c, bus.data_sram_rdata, bus.addr_err);
      end
    end
    apply_reset();
    count_clear("mid_clear_len");
    check_all_words("mid_clear_zero");
  endtask

  initial begin
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'b0000;
    bus.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    for (int w = 0; w < DEPTH; w++) model[w] = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_clear();
    test_full_word();
    test_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
